inst_fetch_loader: RTL and testbench

- Upstream neighbour of the single-cycle core. Owns the instruction memory and drives the core's `inst_i` from the core's `pc_o`.
- After reset it accepts a program as a byte stream with a valid/ready handshake and packs bytes little-endian into 32-bit words.
- It holds the core in reset while loading, then releases the core and serves combinational fetches.
- Supports reload at runtime, and reports overflow and out-of-range fetch errors.

---
 rtl/ifl_pkg.sv | 30 +++
 rtl/inst_mem_1w1r.sv | 28 ++
 rtl/inst_fetch_loader.sv | 158 +++++++++++++++
 tb/tb_inst_fetch_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifl_pkg.sv
// Shared types and constants for the instruction fetch loader.
package ifl_pkg;

    // Loader phases: stream bytes in, flush a partial word, hold the core
    // in reset for one more cycle, then serve fetches.
    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        PAD     = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } ifl_state_e;

    // addi x0, x0, 0: returned whenever no valid instruction exists.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Byte lanes within a 32-bit word, lane 0 = bits 7:0.
    localparam int         LANE_W    = 8;
    localparam logic [1:0] LAST_LANE = 2'd3;

    // Keeps the lowest nbytes lanes of a word and clears the rest.
    function automatic logic [31:0] lane_mask(input logic [1:0] nbytes);
        case (nbytes)
            2'd1:    return 32'h0000_00FF;
            2'd2:    return 32'h0000_FFFF;
            2'd3:    return 32'h00FF_FFFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/inst_mem_1w1r.sv
// Instruction store: one synchronous write port, one combinational read
// port, no reset on the contents so it maps onto distributed RAM.
module inst_mem_1w1r
    import ifl_pkg::*;
#(
    parameter int n      = 32,
    parameter int n_addr = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [n_addr-1:0] waddr_i,
    input  logic [n-1:0]      wdata_i,
    input  logic [n_addr-1:0] raddr_i,
    output logic [n-1:0]      rdata_o
);

    logic [n-1:0] mem [2**n_addr];

    // Write port: one word per enabled edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/inst_fetch_loader.sv
// Loads a little-endian byte stream into instruction memory while holding
// the core in reset, then releases the core and serves zero-latency fetches.
module inst_fetch_loader
    import ifl_pkg::*;
#(
    parameter int          n      = 32,
    parameter int          n_addr = 10,
    parameter logic [31:0] NOP    = NOP_INSTR
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            prog_valid_i,
    input  logic [7:0]      prog_byte_i,
    input  logic            prog_last_i,
    output logic            prog_ready_o,
    input  logic            reload_i,
    input  logic [n-1:0]    pc_i,
    output logic [n-1:0]    inst_o,
    output logic            core_rst_no,
    output logic [n_addr:0] word_cnt_o,
    output logic            ovf_o,
    output logic            fetch_err_o
);

    localparam logic [n_addr:0] DEPTH   = {1'b1, {n_addr{1'b0}}};
    localparam logic [n_addr:0] CNT_ONE = {{n_addr{1'b0}}, 1'b1};
    localparam int              PC_W    = n - 2;

    ifl_state_e        state_q, state_d;
    logic [1:0]        byte_idx_q;
    logic [n_addr:0]   word_cnt_q;
    logic              ovf_q;
    logic              fetch_err_q;
    logic [LANE_W-1:0] lane0_q, lane1_q, lane2_q;

    logic              full;
    logic              xfer;
    logic              word_done;
    logic              mem_we;
    logic              fetch_ok;
    logic [n-1:0]      packed_word;
    logic [n-1:0]      mem_wdata;
    logic [n-1:0]      mem_rdata;
    logic [PC_W-1:0]   pc_word;

    // A full memory still accepts bytes (they are dropped and flagged);
    // reload wins over any byte presented in the same cycle.
    assign full        = (word_cnt_q == DEPTH);
    assign xfer        = prog_valid_i && (state_q == LOAD) && !reload_i;
    assign word_done   = xfer && (byte_idx_q == LAST_LANE);
    assign packed_word = {prog_byte_i, lane2_q, lane1_q, lane0_q};
    assign mem_we      = !full && !reload_i && (word_done || (state_q == PAD));
    // In PAD the lanes at and above byte_idx hold stale bytes, so mask them.
    assign mem_wdata   = (state_q == PAD) ? (packed_word & lane_mask(byte_idx_q))
                                          : packed_word;

    // Fetch is legal only word-aligned and below the loaded word count;
    // the full PC is compared so high addresses cannot alias into memory.
    assign pc_word  = pc_i[n-1:2];
    assign fetch_ok = (pc_i[1:0] == 2'b00) && (pc_word < PC_W'(word_cnt_q));

    assign word_cnt_o  = word_cnt_q;
    assign ovf_o       = ovf_q;
    assign fetch_err_o = fetch_err_q;

    inst_mem_1w1r #(
        .n      (n),
        .n_addr (n_addr)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (word_cnt_q[n_addr-1:0]),
        .wdata_i (mem_wdata),
        .raddr_i (pc_i[n_addr+1:2]),
        .rdata_o (mem_rdata)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-derived outputs.
    always_comb begin
        state_d      = state_q;
        prog_ready_o = 1'b0;
        core_rst_no  = 1'b0;
        inst_o       = NOP;
        case (state_q)
            LOAD: begin
                prog_ready_o = 1'b1;
                if (xfer && prog_last_i) begin
                    state_d = (byte_idx_q == LAST_LANE) ? RELEASE : PAD;
                end
            end
            PAD:     state_d = RELEASE;
            RELEASE: state_d = RUN;
            RUN: begin
                core_rst_no = 1'b1;
                if (fetch_ok) begin
                    inst_o = mem_rdata;
                end
            end
            default: state_d = LOAD;
        endcase
        if (reload_i) begin
            state_d = LOAD;
        end
    end

    // Byte lane, word count and sticky error bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_idx_q  <= 2'd0;
            word_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            fetch_err_q <= 1'b0;
        end else if (reload_i) begin
            byte_idx_q  <= 2'd0;
            word_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            if (xfer) begin
                byte_idx_q <= byte_idx_q + 2'd1;
                if (full) begin
                    ovf_q <= 1'b1;
                end
            end else if (state_q == PAD) begin
                byte_idx_q <= 2'd0;
            end
            if (mem_we) begin
                word_cnt_q <= word_cnt_q + CNT_ONE;
            end
            if ((state_q == RUN) && !fetch_ok) begin
                fetch_err_q <= 1'b1;
            end
        end
    end

    // Assembly lanes for the first three bytes of a word; the fourth byte
    // goes straight from the input into the memory write.
    always_ff @(posedge clk_i) begin
        if (xfer) begin
            case (byte_idx_q)
                2'd0:    lane0_q <= prog_byte_i;
                2'd1:    lane1_q <= prog_byte_i;
                2'd2:    lane2_q <= prog_byte_i;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_loader.sv
// Bench for inst_fetch_loader with a 4-word memory.
module tb_inst_fetch_loader;

    localparam int          N_ADDR = 2;
    localparam int          DEPTH  = 1 << N_ADDR;
    localparam logic [31:0] NOPW   = 32'h0000_0013;

    logic              clk_i;
    logic              rst_ni;
    logic              prog_valid_i;
    logic [7:0]        prog_byte_i;
    logic              prog_last_i;
    logic              prog_ready_o;
    logic              reload_i;
    logic [31:0]       pc_i;
    logic [31:0]       inst_o;
    logic              core_rst_no;
    logic [N_ADDR:0]   word_cnt_o;
    logic              ovf_o;
    logic              fetch_err_o;

    int npass = 0;
    int ntot  = 0;

    logic [31:0] exp_mem [DEPTH];
    int          exp_wc;
    bit          exp_ovf;
    bit          exp_err;

    inst_fetch_loader #(
        .n      (32),
        .n_addr (N_ADDR)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .prog_valid_i (prog_valid_i),
        .prog_byte_i  (prog_byte_i),
        .prog_last_i  (prog_last_i),
        .prog_ready_o (prog_ready_o),
        .reload_i     (reload_i),
        .pc_i         (pc_i),
        .inst_o       (inst_o),
        .core_rst_no  (core_rst_no),
        .word_cnt_o   (word_cnt_o),
        .ovf_o        (ovf_o),
        .fetch_err_o  (fetch_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: what a complete program image should look like in memory.
    task automatic build_model(input logic [7:0] q[$]);
        int nw;
        for (int w = 0; w < DEPTH; w++) exp_mem[w] = 32'h0;
        for (int i = 0; i < q.size(); i++) begin
            if (i / 4 < DEPTH) exp_mem[i / 4][8 * (i % 4) +: 8] = q[i];
        end
        nw      = (q.size() + 3) / 4;
        exp_wc  = (nw > DEPTH) ? DEPTH : nw;
        exp_ovf = (q.size() > 4 * DEPTH);
    endtask

    task automatic send(input logic [7:0] q[$], input bit with_last, input bit gaps);
        int c = 0;
        int fw;
        for (int i = 0; i < q.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    prog_valid_i = 1'b0;
                    @(negedge clk_i);
                end
            end
            prog_valid_i = 1'b1;
            prog_byte_i  = q[i];
            prog_last_i  = with_last && (i == q.size() - 1);
            @(negedge clk_i);
            c++;
            fw = (c / 4 > DEPTH) ? DEPTH : c / 4;
            chk("wcnt_load", word_cnt_o, fw);
            chk("ovf_load", ovf_o, (c > 4 * DEPTH));
            chk("ready_load", prog_ready_o, !(with_last && (i == q.size() - 1)));
        end
        prog_valid_i = 1'b0;
        prog_last_i  = 1'b0;
    endtask

    // Called right after the last transfer: core stays in reset for one
    // cycle, plus one more when a partial word has to be padded.
    task automatic finish_load(input logic [7:0] q[$]);
        int extra;
        build_model(q);
        extra = (q.size() % 4 != 0) ? 1 : 0;
        for (int k = 0; k <= extra; k++) begin
            chk("core_rst_hold", core_rst_no, 1'b0);
            chk("ready_hold", prog_ready_o, 1'b0);
            chk("inst_hold", inst_o, NOPW);
            @(negedge clk_i);
        end
        chk("core_rst_run", core_rst_no, 1'b1);
        chk("wcnt_final", word_cnt_o, exp_wc);
        chk("ovf_final", ovf_o, exp_ovf);
        chk("ferr_start", fetch_err_o, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] pc);
        int widx;
        bit ok;
        widx = int'(pc >> 2);
        ok   = (pc[1:0] == 2'b00) && (widx < exp_wc);
        pc_i = pc;
        #1;
        chk("inst", inst_o, ok ? exp_mem[widx] : NOPW);
        if (!ok) exp_err = 1'b1;
        @(negedge clk_i);
        chk("ferr", fetch_err_o, exp_err);
    endtask

    task automatic do_reload();
        reload_i = 1'b1;
        @(negedge clk_i);
        reload_i = 1'b0;
        exp_err  = 1'b0;
        chk("rl_core", core_rst_no, 1'b0);
        chk("rl_wcnt", word_cnt_o, 0);
        chk("rl_ready", prog_ready_o, 1'b1);
        chk("rl_ovf", ovf_o, 1'b0);
        chk("rl_ferr", fetch_err_o, 1'b0);
        chk("rl_inst", inst_o, NOPW);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        int len;

        rst_ni       = 1'b0;
        prog_valid_i = 1'b0;
        prog_byte_i  = 8'h0;
        prog_last_i  = 1'b0;
        reload_i     = 1'b0;
        pc_i         = 32'h0;
        exp_err      = 1'b0;
        #12;
        chk("rst_ready", prog_ready_o, 1'b1);
        chk("rst_core", core_rst_no, 1'b0);
        chk("rst_wcnt", word_cnt_o, 0);
        chk("rst_ovf", ovf_o, 1'b0);
        chk("rst_ferr", fetch_err_o, 1'b0);
        chk("rst_inst", inst_o, NOPW);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Two complete words.
        q = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        send(q, 1'b1, 1'b0);
        finish_load(q);
        fetch(32'h0);
        chk("t1_w0", inst_o, 32'h0050_0513);
        fetch(32'h4);
        chk("t1_w1", inst_o, 32'h0010_0593);
        // Misaligned, then aligned but past the loaded words.
        fetch(32'h6);
        chk("t1_err_mis", fetch_err_o, 1'b1);
        fetch(32'h8);
        chk("t1_err_oor", fetch_err_o, 1'b1);

        // Reload in RUN; then a byte coincident with reload must be dropped.
        do_reload();
        reload_i     = 1'b1;
        prog_valid_i = 1'b1;
        prog_byte_i  = 8'hEE;
        @(negedge clk_i);
        reload_i     = 1'b0;
        prog_valid_i = 1'b0;
        chk("drop_wcnt", word_cnt_o, 0);
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send(q, 1'b1, 1'b0);
        finish_load(q);
        fetch(32'h0);
        chk("drop_word", inst_o, 32'h4433_2211);

        // Partial final word goes through PAD.
        do_reload();
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        send(q, 1'b1, 1'b1);
        finish_load(q);
        fetch(32'h0);
        fetch(32'h4);
        chk("pad_word", inst_o, 32'h0000_2211);

        // Overflow: 20 bytes into a 4-word memory.
        do_reload();
        q = {};
        for (int i = 1; i <= 20; i++) q.push_back(8'(i));
        send(q, 1'b1, 1'b0);
        finish_load(q);
        fetch(32'hC);
        chk("ovf_w3", inst_o, 32'h100F_0E0D);
        fetch(32'h10);
        do_reload();

        // Randomized programs, gaps and fetch addresses.
        for (int r = 0; r < 25; r++) begin
            do_reload();
            len = $urandom_range(1, 20);
            q = {};
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            send(q, 1'b1, 1'b1);
            finish_load(q);
            for (int w = 0; w < DEPTH; w++) fetch(32'(w * 4));
            for (int k = 0; k < 6; k++) begin
                case ($urandom_range(0, 3))
                    0: fetch(32'($urandom_range(0, DEPTH + 1)) << 2);
                    1: fetch((32'($urandom_range(0, DEPTH)) << 2) | 32'($urandom_range(1, 3)));
                    2: fetch($urandom);
                    default: fetch(32'($urandom_range(0, DEPTH - 1)) << 2);
                endcase
            end
        end

        // Asynchronous reset with two bytes of a word pending and ovf set.
        do_reload();
        q = {};
        for (int i = 0; i < 18; i++) q.push_back(8'($urandom));
        send(q, 1'b0, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_wcnt", word_cnt_o, 0);
        chk("arst_ovf", ovf_o, 1'b0);
        chk("arst_core", core_rst_no, 1'b0);
        chk("arst_ready", prog_ready_o, 1'b1);
        chk("arst_inst", inst_o, NOPW);
        chk("arst_ferr", fetch_err_o, 1'b0);
        @(negedge clk_i);
        rst_ni  = 1'b1;
        exp_err = 1'b0;
        q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send(q, 1'b1, 1'b0);
        finish_load(q);
        fetch(32'h0);
        chk("arst_lane0", inst_o, 32'hD4C3_B2A1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
